fp_adder_arbiter: RTL and testbench

Shares one pipelined single-precision FP adder between NUM_REQ requesters. Round-robin arbitration with a per-requester valid/ready handshake issues at most one operand pair per cycle into a registered issue stage driving the adder. A tag pipeline matched to the adder latency routes each result back to its requester. Operands and results are opaque 32-bit words; the arbiter does no arithmetic and no field decoding on them.

---
 rtl/fp_adder_arbiter_pkg.sv | 11 +
 rtl/fp_adder_arbiter_rr_arbiter.sv | 31 +++
 rtl/fp_adder_arbiter.sv | 98 +++++++++
 tb/tb_fp_adder_arbiter.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_adder_arbiter_pkg.sv
// Shared definitions for the FP adder arbiter: requester index width derivation.
package fp_adder_arbiter_pkg;

  function automatic int id_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/fp_adder_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester at or above ptr, with wrap-around.
module rr_arbiter
  import fp_adder_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_id
);

  always_comb begin
    int  j;
    logic found;
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    j        = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = (int'(ptr) + k) % NUM_REQ;
      if (!found && req[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        grant_id = ID_W'(j);
      end
    end
  end

endmodule

// File: rtl/fp_adder_arbiter.sv
// Shares one pipelined FP adder among NUM_REQ requesters; results return via a tag pipe.
module fp_adder_arbiter
  import fp_adder_arbiter_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int WORD_WIDTH  = 32,
  parameter int ADD_LATENCY = 1,
  parameter int ID_W        = id_width(NUM_REQ),
  parameter int CNT_W       = 16
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*WORD_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WORD_WIDTH-1:0] req_b,
  input  logic                          hold,
  output logic [WORD_WIDTH-1:0]         add_in1,
  output logic [WORD_WIDTH-1:0]         add_in2,
  input  logic [WORD_WIDTH-1:0]         add_out,
  output logic [NUM_REQ-1:0]            resp_valid,
  output logic [ID_W-1:0]               resp_id,
  output logic [WORD_WIDTH-1:0]         resp_data,
  output logic                          busy,
  output logic [CNT_W-1:0]              issue_count
);

  logic [ID_W-1:0]        rr_ptr;
  logic [NUM_REQ-1:0]     grant;
  logic [ID_W-1:0]        grant_id;
  logic                   accept;
  logic                   iss_valid;
  logic [ID_W-1:0]        iss_id;
  logic [ADD_LATENCY-1:0] tag_valid;
  logic [ID_W-1:0]        tag_id [ADD_LATENCY];

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr (
    .req      (req_valid),
    .ptr      (rr_ptr),
    .grant    (grant),
    .grant_id (grant_id)
  );

  // No downstream backpressure: the only gating is reset and hold.
  assign req_ready = (reset_n && !hold) ? grant : '0;
  assign accept    = |req_ready;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rr_ptr      <= '0;
      iss_valid   <= 1'b0;
      iss_id      <= '0;
      add_in1     <= '0;
      add_in2     <= '0;
      issue_count <= '0;
    end else begin
      iss_valid <= accept;
      if (accept) begin
        add_in1     <= req_a[int'(grant_id)*WORD_WIDTH +: WORD_WIDTH];
        add_in2     <= req_b[int'(grant_id)*WORD_WIDTH +: WORD_WIDTH];
        iss_id      <= grant_id;
        rr_ptr      <= (int'(grant_id) == NUM_REQ-1) ? '0 : grant_id + 1'b1;
        issue_count <= issue_count + 1'b1;
      end
    end
  end

  // Tag pipe mirrors the adder latency so the last stage lines up with add_out.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tag_valid <= '0;
      for (int k = 0; k < ADD_LATENCY; k++) tag_id[k] <= '0;
    end else begin
      tag_valid[0] <= iss_valid;
      tag_id[0]    <= iss_id;
      for (int k = 1; k < ADD_LATENCY; k++) begin
        tag_valid[k] <= tag_valid[k-1];
        tag_id[k]    <= tag_id[k-1];
      end
    end
  end

  always_comb begin
    resp_valid = '0;
    resp_id    = '0;
    if (tag_valid[ADD_LATENCY-1]) begin
      resp_valid[tag_id[ADD_LATENCY-1]] = 1'b1;
      resp_id                           = tag_id[ADD_LATENCY-1];
    end
  end

  assign resp_data = add_out;
  assign busy      = iss_valid | (|tag_valid);

endmodule

// File: tb/tb_fp_adder_arbiter.sv
// Self-checking bench: integer adder stand-in, queue-based reference model of grants and responses.
module tb_fp_adder_arbiter;
  localparam int N  = 4;
  localparam int W  = 32;
  localparam int CW = 4;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic           hold = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_ready;
  logic [W-1:0]   ra [N];
  logic [W-1:0]   rb [N];
  logic [N*W-1:0] req_a, req_b;
  logic [W-1:0]   add_in1, add_in2, add_out;
  logic [N-1:0]   resp_valid;
  logic [1:0]     resp_id;
  logic [W-1:0]   resp_data;
  logic           busy;
  logic [CW-1:0]  issue_count;

  fp_adder_arbiter #(
    .NUM_REQ(N), .WORD_WIDTH(W), .ADD_LATENCY(1), .ID_W(2), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .hold(hold), .add_in1(add_in1), .add_in2(add_in2),
    .add_out(add_out), .resp_valid(resp_valid), .resp_id(resp_id), .resp_data(resp_data),
    .busy(busy), .issue_count(issue_count)
  );

  always #5 clk = ~clk;

  always_comb begin
    req_a = '0;
    req_b = '0;
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = ra[i];
      req_b[i*W +: W] = rb[i];
    end
  end

  // Behavioural adder: one registered stage of integer addition.
  always_ff @(posedge clk) add_out <= add_in1 + add_in2;

  typedef struct {
    int         id;
    logic [W-1:0] data;
    int         due;
  } exp_t;

  exp_t         q[$];
  int           mptr = 0, mcount = 0, cyc = 0, last_g = -1;
  int           pass_cnt = 0, total_cnt = 0;
  logic [N-1:0] e_valid;
  logic [1:0]   e_id;
  logic [W-1:0] e_data;
  logic         e_busy;
  logic [N-1:0] exp_r;

  function automatic int mgrant();
    if (!reset_n || hold) return -1;
    for (int k = 0; k < N; k++) begin
      int j = (mptr + k) % N;
      if (req_valid[j]) return j;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(input int g);
    return (g < 0) ? '0 : (N'(1) << g);
  endfunction

  // Advance one clock edge, update the model, and publish the expected response state.
  task automatic tick();
    int g;
    g = mgrant();
    if (g >= 0) begin
      q.push_back('{g, ra[g] + rb[g], cyc + 2});
      mptr = (g + 1) % N;
      mcount++;
    end
    last_g = g;
    @(posedge clk);
    cyc++;
    if (!reset_n) begin
      q.delete();
      mptr   = 0;
      mcount = 0;
    end
    #1;
    e_valid = '0; e_id = '0; e_data = '0; e_busy = 1'b0;
    foreach (q[k]) if (q[k].due >= cyc) e_busy = 1'b1;
    if (q.size() > 0 && q[0].due == cyc) begin
      e_valid = N'(1) << q[0].id;
      e_id    = 2'(q[0].id);
      e_data  = q[0].data;
      void'(q.pop_front());
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; req_valid = '1; hold = 1'b0;
    #1;
    total_cnt++;
    if (req_ready !== '0) $display("FAIL reset_ready got=%b exp=0000", req_ready); else pass_cnt++;
    tick(); tick();
    total_cnt++;
    if ({resp_valid, resp_id, busy, issue_count, add_in1, add_in2} !== '0)
      $display("FAIL reset_state got rv=%b id=%0d busy=%b cnt=%0d in1=%h in2=%h exp all zero",
               resp_valid, resp_id, busy, issue_count, add_in1, add_in2);
    else pass_cnt++;
    req_valid = '0;
  endtask

  task automatic test_reset_midflight();
    reset_n = 1'b1; req_valid = 4'b0001; ra[0] = 5; rb[0] = 7;
    #1;
    total_cnt++;
    if (req_ready !== 4'b0001) $display("FAIL mid_ready got=%b exp=0001", req_ready); else pass_cnt++;
    tick();
    req_valid = '0; reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) tick();
      total_cnt++;
      if (resp_valid !== '0 || busy !== 1'b0)
        $display("FAIL mid_discard cyc=%0d got rv=%b busy=%b exp rv=0000 busy=0", cyc, resp_valid, busy);
      else pass_cnt++;
    end
    total_cnt++;
    if (issue_count !== '0) $display("FAIL mid_count got=%0d exp=0", issue_count); else pass_cnt++;
  endtask

  task automatic test_single();
    req_valid = 4'b0010; ra[1] = 32'h10; rb[1] = 32'h20;
    #1;
    total_cnt++;
    if (req_ready !== 4'b0010) $display("FAIL single_ready got=%b exp=0010", req_ready); else pass_cnt++;
    tick();
    req_valid = '0;
    tick();
    total_cnt++;
    if (resp_valid !== 4'b0010 || resp_id !== 2'd1 || resp_data !== 32'h30 || issue_count !== 4'd1)
      $display("FAIL single_resp got rv=%b id=%0d data=%h cnt=%0d exp rv=0010 id=1 data=30 cnt=1",
               resp_valid, resp_id, resp_data, issue_count);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_all_valid();
    reset_n = 1'b0; tick(); reset_n = 1'b1;
    for (int i = 0; i < N; i++) begin ra[i] = $urandom; rb[i] = $urandom; end
    req_valid = '1;
    for (int i = 0; i < 10; i++) begin
      if (i == 8) req_valid = '0;
      #1;
      exp_r = (i < 8) ? onehot(i % N) : '0;
      total_cnt++;
      if (req_ready !== exp_r || exp_r !== onehot(mgrant()))
        $display("FAIL all_ready cyc=%0d got=%b exp=%b", cyc, req_ready, exp_r);
      else pass_cnt++;
      tick();
      total_cnt++;
      if ({resp_valid, resp_id, busy} !== {e_valid, e_id, e_busy} || (e_valid != 0 && resp_data !== e_data))
        $display("FAIL all_resp cyc=%0d got rv=%b id=%0d data=%h busy=%b exp rv=%b id=%0d data=%h busy=%b",
                 cyc, resp_valid, resp_id, resp_data, busy, e_valid, e_id, e_data, e_busy);
      else pass_cnt++;
      if (last_g >= 0) begin ra[last_g] = $urandom; rb[last_g] = $urandom; end
    end
    total_cnt++;
    if (issue_count !== 4'd8) $display("FAIL all_count got=%0d exp=8", issue_count); else pass_cnt++;
  endtask

  task automatic test_wrap();
    logic [N-1:0] vseq [4];
    logic [N-1:0] rseq [4];
    vseq = '{4'b1000, 4'b0101, 4'b0100, 4'b0000};
    rseq = '{4'b1000, 4'b0001, 4'b0100, 4'b0000};
    for (int i = 0; i < 6; i++) begin
      req_valid = (i < 4) ? vseq[i] : '0;
      #1;
      exp_r = (i < 4) ? rseq[i] : '0;
      total_cnt++;
      if (req_ready !== exp_r) $display("FAIL wrap_ready step=%0d got=%b exp=%b", i, req_ready, exp_r);
      else pass_cnt++;
      tick();
      total_cnt++;
      if ({resp_valid, resp_id, busy} !== {e_valid, e_id, e_busy} || (e_valid != 0 && resp_data !== e_data))
        $display("FAIL wrap_resp cyc=%0d got rv=%b id=%0d data=%h exp rv=%b id=%0d data=%h",
                 cyc, resp_valid, resp_id, resp_data, e_valid, e_id, e_data);
      else pass_cnt++;
    end
  endtask

  task automatic test_hold();
    req_valid = 4'b1000; ra[3] = $urandom; rb[3] = $urandom;
    tick();
    hold = 1'b1; req_valid = 4'b0101;
    for (int i = 0; i < 3; i++) begin
      #1;
      total_cnt++;
      if (req_ready !== '0) $display("FAIL hold_ready cyc=%0d got=%b exp=0000", cyc, req_ready); else pass_cnt++;
      tick();
      total_cnt++;
      if ({resp_valid, resp_id, busy} !== {e_valid, e_id, e_busy} || (e_valid != 0 && resp_data !== e_data))
        $display("FAIL hold_resp cyc=%0d got rv=%b id=%0d busy=%b exp rv=%b id=%0d busy=%b",
                 cyc, resp_valid, resp_id, busy, e_valid, e_id, e_busy);
      else pass_cnt++;
    end
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL hold_busy got=%b exp=0", busy); else pass_cnt++;
    hold = 1'b0;
    #1;
    total_cnt++;
    if (req_ready !== 4'b0001) $display("FAIL hold_release got=%b exp=0001", req_ready); else pass_cnt++;
    tick();
    req_valid = '0;
    tick(); tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 64; i++) begin
      hold = (i < 60) && ($urandom_range(3) == 0);
      for (int r = 0; r < N; r++)
        if (!req_valid[r] && i < 60 && $urandom_range(1) == 1) begin
          req_valid[r] = 1'b1; ra[r] = $urandom; rb[r] = $urandom;
        end
      if (i >= 60) req_valid = '0;
      #1;
      exp_r = onehot(mgrant());
      total_cnt++;
      if (req_ready !== exp_r) $display("FAIL rand_ready cyc=%0d got=%b exp=%b", cyc, req_ready, exp_r);
      else pass_cnt++;
      tick();
      if (last_g >= 0) req_valid[last_g] = 1'b0;
      total_cnt++;
      if ({resp_valid, resp_id, busy} !== {e_valid, e_id, e_busy} || (e_valid != 0 && resp_data !== e_data)
          || issue_count !== CW'(mcount))
        $display("FAIL rand_resp cyc=%0d got rv=%b id=%0d data=%h busy=%b cnt=%0d exp rv=%b id=%0d data=%h busy=%b cnt=%0d",
                 cyc, resp_valid, resp_id, resp_data, busy, issue_count, e_valid, e_id, e_data, e_busy, CW'(mcount));
      else pass_cnt++;
    end
  endtask

  task automatic test_counter_wrap();
    reset_n = 1'b0; hold = 1'b0; tick(); reset_n = 1'b1;
    req_valid = 4'b0001;
    for (int i = 0; i < 19; i++) begin
      if (i == 17) req_valid = '0;
      ra[0] = $urandom; rb[0] = $urandom;
      tick();
      total_cnt++;
      if ({resp_valid, resp_id, busy} !== {e_valid, e_id, e_busy} || (e_valid != 0 && resp_data !== e_data))
        $display("FAIL wrap_cnt_resp cyc=%0d got rv=%b data=%h exp rv=%b data=%h",
                 cyc, resp_valid, resp_data, e_valid, e_data);
      else pass_cnt++;
    end
    total_cnt++;
    if (issue_count !== 4'd1) $display("FAIL counter_wrap got=%0d exp=1", issue_count); else pass_cnt++;
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin ra[i] = '0; rb[i] = '0; end
    test_reset();
    test_reset_midflight();
    test_single();
    test_all_valid();
    test_wrap();
    test_hold();
    test_random();
    test_counter_wrap();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
